// File: rtl/sram_mem_controller.sv
// Sequences 32-bit MEM-stage loads/stores onto a 16-bit asynchronous SRAM as two
// halfword phases of WAIT_CYCLES cycles each, stalling the pipeline via ready.
module sram_mem_controller #(
  parameter int WAIT_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrEn,
  input  logic        rdEn,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic [17:0] sramAddr,
  output logic [15:0] sramDataOut,
  output logic        sramDataOe,
  output logic        sramWeN,
  input  logic [15:0] sramDataIn
);

  typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, RD_LO, RD_HI, DONE} state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [16:0] idx;
  logic [16:0] idx_q;
  logic [15:0] wdata_hi_q;
  logic        req;
  logic        last;

  assign req   = wrEn | rdEn;
  assign idx   = 17'((address - 32'd1024) >> 2);
  assign last  = (cnt == LAST);
  assign ready = ~req | (state == DONE);

  // Request capture: only the high-phase values are needed after the IDLE cycle
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      idx_q      <= idx;
      wdata_hi_q <= writeData[31:16];
    end
  end

  // Phase sequencer with registered SRAM strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      readData    <= '0;
      sramAddr    <= '0;
      sramDataOut <= '0;
      sramDataOe  <= 1'b0;
      sramWeN     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            cnt      <= '0;
            sramAddr <= {idx, 1'b0};
            if (wrEn) begin
              state       <= WR_LO;
              sramDataOut <= writeData[15:0];
              sramDataOe  <= 1'b1;
              sramWeN     <= 1'b0;
            end else begin
              state <= RD_LO;
            end
          end
        end
        WR_LO: begin
          if (last) begin
            cnt         <= '0;
            state       <= WR_HI;
            sramAddr    <= {idx_q, 1'b1};
            sramDataOut <= wdata_hi_q;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        WR_HI: begin
          if (last) begin
            cnt        <= '0;
            state      <= DONE;
            sramDataOe <= 1'b0;
            sramWeN    <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RD_LO: begin
          if (last) begin
            cnt            <= '0;
            state          <= RD_HI;
            readData[15:0] <= sramDataIn;
            sramAddr       <= {idx_q, 1'b1};
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RD_HI: begin
          if (last) begin
            cnt             <= '0;
            state           <= DONE;
            readData[31:16] <= sramDataIn;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed bench for sram_mem_controller with a small behavioural SRAM model.
module tb_sram_mem_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrEn, rdEn;
  logic [31:0] address, writeData;
  logic [31:0] readData;
  logic        ready;
  logic [17:0] sramAddr;
  logic [15:0] sramDataOut;
  logic        sramDataOe, sramWeN;
  logic [15:0] sramDataIn;

  logic [15:0] mem [0:1023];
  int checks = 0;
  int errors = 0;

  sram_mem_controller #(.WAIT_CYCLES(5)) dut (
    .clk(clk), .rst(rst), .wrEn(wrEn), .rdEn(rdEn), .address(address),
    .writeData(writeData), .readData(readData), .ready(ready),
    .sramAddr(sramAddr), .sramDataOut(sramDataOut), .sramDataOe(sramDataOe),
    .sramWeN(sramWeN), .sramDataIn(sramDataIn)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM: write committed at each clock while WE# is low
  always @(posedge clk) if (!sramWeN) mem[sramAddr[9:0]] <= sramDataOut;
  assign sramDataIn = mem[sramAddr[9:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full access: cycle 0 (IDLE, req seen) through cycle 11 (DONE), then release
  task automatic access(input string nm, input logic wr, input logic rd,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [17:0] lo, input logic [31:0] rd_exp);
    @(negedge clk);
    wrEn = wr; rdEn = rd; address = a; writeData = wd;
    #1;
    check({nm, "_c0_ready"}, ready, 0);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      #1;
      if (c <= 10) begin
        check($sformatf("%s_c%0d_ready", nm, c), ready, 0);
        check($sformatf("%s_c%0d_addr", nm, c), sramAddr, (c <= 5) ? lo : lo + 18'd1);
        check($sformatf("%s_c%0d_wen", nm, c), sramWeN, wr ? 0 : 1);
        check($sformatf("%s_c%0d_oe", nm, c), sramDataOe, wr ? 1 : 0);
        if (wr)
          check($sformatf("%s_c%0d_dout", nm, c), sramDataOut,
                (c <= 5) ? {16'h0, wd[15:0]} : {16'h0, wd[31:16]});
        if (!wr && c == 6)
          check({nm, "_c6_rdlo"}, readData[15:0], rd_exp[15:0]);
      end else begin
        check({nm, "_c11_ready"}, ready, 1);
        check({nm, "_c11_wen"}, sramWeN, 1);
        check({nm, "_c11_oe"}, sramDataOe, 0);
        check({nm, "_c11_rdata"}, readData, rd_exp);
      end
    end
    @(negedge clk);
    wrEn = 0; rdEn = 0;
    #1;
    check({nm, "_c12_ready"}, ready, 1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
    rst = 1; wrEn = 0; rdEn = 0; address = 0; writeData = 0;
    #1;
    check("rst_rdata", readData, 0);
    check("rst_addr", sramAddr, 0);
    check("rst_dout", sramDataOut, 0);
    check("rst_oe", sramDataOe, 0);
    check("rst_wen", sramWeN, 1);
    check("rst_ready_noreq", ready, 1);
    wrEn = 1; #1;
    check("rst_ready_req", ready, 0);
    wrEn = 0;
    @(negedge clk); @(negedge clk);
    rst = 0;

    access("store", 1, 0, 32'd1032, 32'hDEADBEEF, 18'd4, 32'h0);
    check("store_mem4", mem[4], 16'hBEEF);
    check("store_mem5", mem[5], 16'hDEAD);

    access("load", 0, 1, 32'd1032, 32'h0, 18'd4, 32'hDEADBEEF);

    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      check($sformatf("idle_c%0d_ready", c), ready, 1);
      check($sformatf("idle_c%0d_wen", c), sramWeN, 1);
      check($sformatf("idle_c%0d_oe", c), sramDataOe, 0);
      check($sformatf("idle_c%0d_addr", c), sramAddr, 18'd5);
    end

    @(negedge clk); rst = 1; #1;
    check("rst2_rdata", readData, 0);
    @(negedge clk); rst = 0;

    access("both", 1, 1, 32'd1024, 32'h12345678, 18'd0, 32'h0);
    check("both_mem0", mem[0], 16'h5678);
    check("both_mem1", mem[1], 16'h1234);

    // Request dropped and address changed mid-operation
    @(negedge clk);
    wrEn = 1; address = 32'd1100; writeData = 32'hCAFEF00D;
    #1;
    check("drop_c0_ready", ready, 0);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 2) address = 32'd2000;
      if (c == 3) wrEn = 0;
      if (c == 11) rdEn = 1;
      #1;
      if (c == 5) begin
        check("drop_c5_addr", sramAddr, 18'd38);
        check("drop_c5_wen", sramWeN, 0);
      end
      if (c == 10) begin
        check("drop_c10_addr", sramAddr, 18'd39);
        check("drop_c10_wen", sramWeN, 0);
        check("drop_c10_dout", sramDataOut, 16'hCAFE);
      end
      if (c == 11) begin
        check("drop_c11_ready_done", ready, 1);
        check("drop_c11_wen", sramWeN, 1);
      end
    end
    @(negedge clk); rdEn = 0; #1;
    check("drop_c12_ready", ready, 1);
    check("drop_mem38", mem[38], 16'hF00D);
    check("drop_mem39", mem[39], 16'hCAFE);
    check("drop_mem488", mem[488], 16'h0);

    // Reset asserted in cycle 7 of a store
    @(negedge clk);
    wrEn = 1; address = 32'd1032; writeData = 32'h11112222;
    #1;
    check("rmid_c0_ready", ready, 0);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 7) rst = 1;
      #1;
      if (c == 6) begin
        check("rmid_c6_wen", sramWeN, 0);
        check("rmid_c6_addr", sramAddr, 18'd5);
      end
      if (c == 7) begin
        check("rmid_c7_wen", sramWeN, 1);
        check("rmid_c7_oe", sramDataOe, 0);
        check("rmid_c7_rdata", readData, 0);
        check("rmid_c7_ready", ready, 0);
      end
    end
    @(negedge clk); rst = 0; wrEn = 0; #1;
    check("rmid_rel_ready", ready, 1);
    access("reload", 0, 1, 32'd1032, 32'h0, 18'd4, 32'h11112222);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_mem_controller.md
# sram_mem_controller

Multi-cycle controller that sequences the pipeline's MEM-stage data accesses onto an external 16-bit asynchronous SRAM. It replaces the single-cycle on-chip data array. It splits each 32-bit load/store into two halfword SRAM phases of programmable length and drives `ready` low so the hazard/freeze logic stalls the pipeline until the access completes.

## Interface
Parameters:
- `WAIT_CYCLES`, default 5: cycles each SRAM halfword phase is held; legal range 1..15.

Ports:
- `clk`: in, 1. Pipeline clock; all state updates on the rising edge.
- `rst`: in, 1. Reset, asynchronous, active-high.
- `wrEn`: in, 1. MEM-stage store request (level, held while stalled).
- `rdEn`: in, 1. MEM-stage load request (level, held while stalled).
- `address`: in, 32. ALU result (byte address).
- `writeData`: in, 32. Store data (Rm value).
- `readData`: out, 32. Registered load result.
- `ready`: out, 1. Combinational; 0 means freeze the pipeline.
- `sramAddr`: out, 18. SRAM halfword address.
- `sramDataOut`: out, 16. Write data to SRAM.
- `sramDataOe`: out, 1. 1 while the controller drives the SRAM data bus.
- `sramWeN`: out, 1. SRAM write enable, active-low.
- `sramDataIn`: in, 16. Read data from SRAM.

## Operation
- Word index: `idx = (address - 1024) >> 2`, computed in 32-bit wrap-around arithmetic with no range check. The low halfword goes to `sramAddr = {idx[16:0],1'b0}` and the high halfword to `{idx[16:0],1'b1}`.
- `req = wrEn | rdEn`. If both are set, the access is a write; `rdEn` is ignored.
- States:
  - IDLE: if `req`, go to WR_LO or RD_LO and clear the counter. Otherwise stay in IDLE.
  - WR_LO: drive the low address, `writeData[15:0]`, `sramDataOe=1` and `sramWeN=0` for WAIT_CYCLES cycles, then go to WR_HI.
  - WR_HI: same with the high address and `writeData[31:16]`, then go to DONE.
  - RD_LO: drive the low address with `sramDataOe=0` and `sramWeN=1`. On the last cycle of the phase, latch `sramDataIn` into `readData[15:0]`, then go to RD_HI.
  - RD_HI: same, latching into `readData[31:16]`, then go to DONE.
  - DONE: one cycle, then IDLE unconditionally.
- `ready = ~req | (state==DONE)`. It is never 0 when no request is present.
- `address`, `writeData` and the read/write decision are sampled into internal registers on the IDLE→phase transition. Input changes after that are ignored until the return to IDLE.
- A request deasserted mid-operation does not abort the operation; the sequence runs to DONE.
- `readData` holds its value until overwritten by the next load; stores never modify it.
- Outside the write phases: `sramWeN=1`, `sramDataOe=0`, and `sramAddr`/`sramDataOut` hold their last value.

## Timing
- Reset values:
  - state IDLE, counter 0
  - `readData=0`, `sramAddr=0`, `sramDataOut=0`
  - `sramDataOe=0`, `sramWeN=1`
  - `ready=~req`
- Cycle numbering: cycle 0 is the IDLE cycle in which `req` is first seen high; `ready=0` in that cycle.
- Cycles 1..W are the LO phase and cycles W+1..2W the HI phase, where W = WAIT_CYCLES.
- DONE is cycle 2W+1, with `ready=1`. With the default W=5, `ready` rises in cycle 11, so the stall is 11 cycles.
- Load data: `readData` is fully valid from the start of DONE. Both halves are captured at the rising edges ending cycles W and 2W.
- Back-to-back accesses: the next instruction's request is seen in the IDLE cycle 2W+2, giving 2W+2 cycles per access.
- `sramWeN` and `sramDataOe` are registered outputs and change only on state transitions. They are glitch-free at the SRAM.
- Reset mid-operation: immediate return to IDLE. `sramWeN=1` and `sramDataOe=0` take effect asynchronously. A partial write (low half only) is acceptable; `readData` is cleared.

## Test plan
- Store, W=5, `address=1032`, `writeData=0xDEADBEEF`:
  - SRAM model sees `0xBEEF` at address 4 with `sramWeN=0` for cycles 1–5.
  - It then sees `0xDEAD` at address 5 for cycles 6–10.
  - `ready=1` only in cycle 11.
- Load after that store, `address=1032`: `readData=0xDEADBEEF` in cycle 11. `sramWeN` stays 1 throughout and `sramDataOe=0`.
- No request: `wrEn=rdEn=0` for 20 cycles gives `ready=1` constantly, with state IDLE, `sramWeN=1` and no SRAM address change.
- Both `wrEn=rdEn=1`, `address=1024`, `writeData=0x12345678`:
  - Performs a write: address 0 gets `0x5678`, address 1 gets `0x1234`.
  - `readData` is unchanged (0 after reset).
- Request dropped at cycle 3, and `address` changed at cycle 2: the write completes to the originally sampled addresses and DONE still occurs in cycle 11.
- Reset asserted in cycle 7 of a store: `sramWeN=1` and `sramDataOe=0` immediately. After release, state is IDLE and `ready=~req`. A new load restarts from cycle 0 and completes in 11 cycles.
